// File: rtl/checker_wb_loader.sv
// checker_wb_loader: Wishbone write master filling checker program memory from a 32-bit word stream.
// Latency: 3 cycles/word (FETCH 1, WRITE 2), 5 with CHECKER_LOADER_VERIFY_EN read-back; done 1 cycle after last ack.
// Backpressure: s_ready only in FETCH; a stalled stream never times out; a stalled bus aborts after ACK_TIMEOUT cycles.
module checker_wb_loader #(
    parameter int LEN_W       = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [31:0]      base_adr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [31:0]      s_dat,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic             wb_stb_o,
    output logic             wb_cyc_o,
    output logic             wb_we_o,
    input  logic             wb_ack_i
`ifdef CHECKER_LOADER_VERIFY_EN
    ,
    output logic [31:0]      fail_adr
`endif
);

    localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
`ifdef CHECKER_LOADER_VERIFY_EN
        ST_VERIFY,
`endif
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             abort_seen_q, abort_seen_d;
    logic             finish_word;
`ifdef CHECKER_LOADER_VERIFY_EN
    logic [31:0]      fail_adr_q, fail_adr_d;
`else
    logic             unused_rd_dat;
    assign unused_rd_dat = ^wb_dat_i;
`endif

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        stb_d        = stb_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        abort_seen_d = abort_seen_q;
`ifdef CHECKER_LOADER_VERIFY_EN
        fail_adr_d   = fail_adr_q;
`endif
        // An abort arriving in the same cycle as the ack still ends the transfer after this word.
        finish_word  = (cnt_q == LEN_W'(1)) || abort_seen_q || abort;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    adr_d        = {base_adr[31:2], 2'b00};
                    cnt_d        = len;
                    err_d        = 1'b0;
                    abort_seen_d = 1'b0;
                    state_d      = (len != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (s_valid) begin
                    dat_d   = s_dat;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                abort_seen_d = abort_seen_q | abort;
                if (wb_ack_i) begin
`ifdef CHECKER_LOADER_VERIFY_EN
                    // Strobe stays up: the read-back follows as a back-to-back cycle.
                    we_d    = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_VERIFY;
`else
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    adr_d   = adr_q + 32'd4;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = finish_word ? ST_DONE : ST_FETCH;
`endif
                end else if (tmo_q == TMO_LAST) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`ifdef CHECKER_LOADER_VERIFY_EN
            ST_VERIFY: begin
                abort_seen_d = abort_seen_q | abort;
                if (wb_ack_i) begin
                    stb_d = 1'b0;
                    if ((wb_dat_i != dat_q) && !err_q) begin
                        err_d      = 1'b1;
                        fail_adr_d = adr_q;
                    end
                    adr_d   = adr_q + 32'd4;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = finish_word ? ST_DONE : ST_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            abort_seen_q <= 1'b0;
`ifdef CHECKER_LOADER_VERIFY_EN
            fail_adr_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            abort_seen_q <= abort_seen_d;
`ifdef CHECKER_LOADER_VERIFY_EN
            fail_adr_q   <= fail_adr_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = stb_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = {4{stb_q}};
    assign s_ready  = (state_q == ST_FETCH);
`ifdef CHECKER_LOADER_VERIFY_EN
    assign fail_adr = fail_adr_q;
`endif

endmodule

// File: tb/tb_checker_wb_loader.sv
// Bench for checker_wb_loader: behavioural Wishbone memory slave, queue-fed stream source,
// expected writes derived as "stream words in order at consecutive word addresses".
module tb_checker_wb_loader;

    localparam int TMO = 4;
`ifdef CHECKER_LOADER_VERIFY_EN
    localparam int CPW = 5;
`else
    localparam int CPW = 3;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [31:0] base_adr;
    logic [15:0] len;
    logic        abort;
    logic        busy, done, err;
    logic [31:0] s_dat;
    logic        s_valid, s_ready;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o, wb_cyc_o, wb_we_o, wb_ack_i;
`ifdef CHECKER_LOADER_VERIFY_EN
    logic [31:0] fail_adr;
`endif

    int          nchecks = 0;
    int          nerrors = 0;
    logic [31:0] stream_q[$];
    bit          stream_en;
    bit          stream_rand;
    int          consumed;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic [31:0] mem[logic [31:0]];
    bit          ack_en;
    bit          corrupt_en;
    logic [31:0] corrupt_adr;
    int          inv_bad = 0;
    logic        nxt_ack;
    logic [31:0] rdata;

    always #5 sys_clk = ~sys_clk;

    checker_wb_loader #(.LEN_W(16), .ACK_TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .base_adr(base_adr),
        .len(len), .abort(abort), .busy(busy), .done(done), .err(err),
        .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i)
`ifdef CHECKER_LOADER_VERIFY_EN
        , .fail_adr(fail_adr)
`endif
    );

    // Memory slave: one-cycle registered ack, logs every acknowledged write.
    always begin
        @(posedge sys_clk);
        nxt_ack = 1'b0;
        if (sys_rst_n === 1'b1) begin
            if (wb_stb_o && wb_ack_i && wb_we_o) begin
                mem[wb_adr_o] = wb_dat_o;
                log_adr.push_back(wb_adr_o);
                log_dat.push_back(wb_dat_o);
            end
            if (wb_sel_o !== (wb_stb_o ? 4'hF : 4'h0) || wb_cyc_o !== wb_stb_o) inv_bad++;
            nxt_ack = wb_stb_o && !wb_ack_i && ack_en;
            if (nxt_ack && !wb_we_o) begin
                rdata = mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'h0;
                if (corrupt_en && wb_adr_o == corrupt_adr) rdata = rdata ^ 32'h0000_0100;
            end
        end
        #2;
        wb_ack_i = nxt_ack;
        wb_dat_i = rdata;
    end

    // Stream source: pops on handshake, optionally drops valid at random.
    always begin
        @(posedge sys_clk);
        if (s_valid && s_ready && stream_q.size() > 0) begin
            consumed++;
            void'(stream_q.pop_front());
        end
        #2;
        s_valid = stream_en && (stream_q.size() > 0) && (!stream_rand || ($urandom_range(0, 3) != 0));
        s_dat   = (stream_q.size() > 0) ? stream_q[0] : 32'h0;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic kick(input logic [31:0] b, input int l);
        start    = 1'b1;
        base_adr = b;
        len      = 16'(l);
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < budget) begin
            step();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic clear_logs();
        log_adr.delete();
        log_dat.delete();
        consumed = 0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        step();
        step();
        nchecks++;
        if ({busy, done, err, wb_stb_o, wb_cyc_o, wb_we_o, s_ready} !== 7'b0) begin
            nerrors++;
            $display("FAIL reset_ctrl got %b want 0000000", {busy, done, err, wb_stb_o, wb_cyc_o, wb_we_o, s_ready});
        end
        nchecks++;
        if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0) begin
            nerrors++;
            $display("FAIL reset_bus got adr=%h dat=%h sel=%h want zeros", wb_adr_o, wb_dat_o, wb_sel_o);
        end
        sys_rst_n = 1'b1;
        step();
        // Reset while a bus cycle is outstanding.
        ack_en = 1'b0;
        stream_q.push_back(32'hA5A5_0001);
        kick(32'h80, 1);
        for (int i = 0; i < 5 && wb_stb_o !== 1'b1; i++) step();
        nchecks++;
        if (wb_stb_o !== 1'b1) begin
            nerrors++;
            $display("FAIL reset_mid_stb got %b want 1", wb_stb_o);
        end
        sys_rst_n = 1'b0;
        step();
        nchecks++;
        if ({wb_stb_o, wb_cyc_o, busy} !== 3'b000 || wb_adr_o !== 32'h0) begin
            nerrors++;
            $display("FAIL reset_mid_drop got stb/cyc/busy=%b adr=%h want 000/0", {wb_stb_o, wb_cyc_o, busy}, wb_adr_o);
        end
        sys_rst_n = 1'b1;
        ack_en    = 1'b1;
        stream_q.delete();
        step();
        clear_logs();
    endtask

    task automatic test_basic();
        logic [31:0] w[3];
        int lat, busy_low;
        w = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D};
        clear_logs();
        foreach (w[i]) stream_q.push_back(w[i]);
        kick(32'h10, 3);
        lat = 1;
        busy_low = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_low++;
            // A start while busy must be ignored.
            start = (lat == 4);
            base_adr = 32'h900;
            len = 16'd1;
            step();
            lat++;
        end
        start = 1'b0;
        nchecks++;
        if (lat !== 3 * CPW + 1) begin
            nerrors++;
            $display("FAIL basic_latency got %0d want %0d", lat, 3 * CPW + 1);
        end
        nchecks++;
        if (err !== 1'b0 || busy !== 1'b1 || busy_low !== 0) begin
            nerrors++;
            $display("FAIL basic_flags got err=%b busy=%b busy_low=%0d want 0/1/0", err, busy, busy_low);
        end
        step();
        nchecks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nerrors++;
            $display("FAIL basic_after got done=%b busy=%b want 0/0", done, busy);
        end
        nchecks++;
        if (log_adr.size() !== 3 || consumed !== 3) begin
            nerrors++;
            $display("FAIL basic_count got %0d writes %0d consumed want 3/3", log_adr.size(), consumed);
        end
        for (int i = 0; i < 3 && i < log_adr.size(); i++) begin
            nchecks++;
            if (log_adr[i] !== 32'h10 + 32'(4 * i) || log_dat[i] !== w[i]) begin
                nerrors++;
                $display("FAIL basic_wr%0d got %h:%h want %h:%h", i, log_adr[i], log_dat[i], 32'h10 + 32'(4 * i), w[i]);
            end
        end
    endtask

    task automatic test_len0();
        int dones, stb_seen, bb, dlat;
        clear_logs();
        dones = 0; stb_seen = 0; bb = 0; dlat = -1;
        kick(32'h20, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            if (done === 1'b1) begin
                dones++;
                if (dlat < 0) dlat = i + 1;
            end
            if (wb_stb_o !== 1'b0) stb_seen++;
            if (busy !== done) bb++;
        end
        nchecks++;
        if (dones !== 1 || !(dlat inside {[1:2]})) begin
            nerrors++;
            $display("FAIL len0_done got %0d pulses at %0d want 1 pulse within 2", dones, dlat);
        end
        nchecks++;
        if (stb_seen !== 0 || bb !== 0 || log_adr.size() !== 0) begin
            nerrors++;
            $display("FAIL len0_bus got stb=%0d busy_bad=%0d writes=%0d want 0/0/0", stb_seen, bb, log_adr.size());
        end
    endtask

    task automatic test_timeout();
        int lat, stb_cyc;
        clear_logs();
        ack_en = 1'b0;
        stream_q.push_back(32'h1111_2222);
        stream_q.push_back(32'h3333_4444);
        kick(32'h100, 2);
        lat = 1;
        stb_cyc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (wb_stb_o === 1'b1) stb_cyc++;
            step();
            lat++;
        end
        nchecks++;
        if (stb_cyc !== TMO || done !== 1'b1) begin
            nerrors++;
            $display("FAIL timeout_stb got %0d cycles done=%b want %0d/1", stb_cyc, done, TMO);
        end
        nchecks++;
        if (err !== 1'b1 || wb_stb_o !== 1'b0 || log_adr.size() !== 0) begin
            nerrors++;
            $display("FAIL timeout_err got err=%b stb=%b writes=%0d want 1/0/0", err, wb_stb_o, log_adr.size());
        end
        step();
        ack_en = 1'b1;
        stream_q.delete();
        clear_logs();
        stream_q.push_back(32'h5555_6666);
        kick(32'h200, 1);
        nchecks++;
        if (err !== 1'b0) begin
            nerrors++;
            $display("FAIL timeout_clear got err=%b want 0", err);
        end
        wait_done(40, lat);
        nchecks++;
        if (lat < 0 || err !== 1'b0 || log_adr.size() !== 1 || (log_adr.size() > 0 && log_adr[0] !== 32'h200)) begin
            nerrors++;
            $display("FAIL timeout_rerun got lat=%0d err=%b writes=%0d want done/0/1 at 200", lat, err, log_adr.size());
        end
        step();
    endtask

    task automatic test_abort();
        logic [31:0] w[5];
        int lat, n;
        clear_logs();
        foreach (w[i]) begin
            w[i] = $urandom;
            stream_q.push_back(w[i]);
        end
        kick(32'h1000, 5);
        n = 0;
        while (!(log_adr.size() == 1 && wb_stb_o === 1'b1 && wb_we_o === 1'b1) && n < 40) begin
            step();
            n++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done(60, lat);
        nchecks++;
        if (lat < 0 || log_adr.size() !== 2) begin
            nerrors++;
            $display("FAIL abort_count got lat=%0d writes=%0d want done/2", lat, log_adr.size());
        end
        for (int i = 0; i < 2 && i < log_adr.size(); i++) begin
            nchecks++;
            if (log_adr[i] !== 32'h1000 + 32'(4 * i) || log_dat[i] !== w[i]) begin
                nerrors++;
                $display("FAIL abort_wr%0d got %h:%h want %h:%h", i, log_adr[i], log_dat[i], 32'h1000 + 32'(4 * i), w[i]);
            end
        end
        step();
        step();
        nchecks++;
        if (consumed !== 2 || stream_q.size() !== 3 || wb_stb_o !== 1'b0 || log_adr.size() !== 2) begin
            nerrors++;
            $display("FAIL abort_stream got consumed=%0d left=%0d stb=%b want 2/3/0", consumed, stream_q.size(), wb_stb_o);
        end
        stream_q.delete();
    endtask

    task automatic test_stall();
        logic [31:0] w[3];
        int lat, bad;
        clear_logs();
        stream_en = 1'b0;
        foreach (w[i]) begin
            w[i] = $urandom;
            stream_q.push_back(w[i]);
        end
        kick(32'h40, 3);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            if (wb_stb_o !== 1'b0 || s_ready !== 1'b1 || done !== 1'b0) bad++;
        end
        nchecks++;
        if (bad !== 0) begin
            nerrors++;
            $display("FAIL stall_hold got %0d bad cycles want 0", bad);
        end
        stream_en = 1'b1;
        wait_done(60, lat);
        nchecks++;
        if (lat < 0 || err !== 1'b0 || log_adr.size() !== 3) begin
            nerrors++;
            $display("FAIL stall_resume got lat=%0d err=%b writes=%0d want done/0/3", lat, err, log_adr.size());
        end
        for (int i = 0; i < 3 && i < log_adr.size(); i++) begin
            nchecks++;
            if (log_adr[i] !== 32'h40 + 32'(4 * i) || log_dat[i] !== w[i]) begin
                nerrors++;
                $display("FAIL stall_wr%0d got %h:%h want %h:%h", i, log_adr[i], log_dat[i], 32'h40 + 32'(4 * i), w[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[4];
        logic [31:0] ea;
        int lat;
        clear_logs();
        foreach (w[i]) w[i] = $urandom;
        stream_q.push_back(w[0]);
        stream_q.push_back(w[1]);
        kick(32'h300, 2);
        wait_done(40, lat);
        // Start in the done cycle is still "while busy".
        start = 1'b1;
        base_adr = 32'h700;
        len = 16'd1;
        step();
        start = 1'b0;
        step();
        nchecks++;
        if (busy !== 1'b0 || wb_stb_o !== 1'b0 || s_ready !== 1'b0) begin
            nerrors++;
            $display("FAIL b2b_ignored got busy=%b stb=%b rdy=%b want 0/0/0", busy, wb_stb_o, s_ready);
        end
        stream_q.push_back(w[2]);
        stream_q.push_back(w[3]);
        kick(32'h400, 2);
        wait_done(40, lat);
        nchecks++;
        if (lat !== 2 * CPW + 1 || log_adr.size() !== 4) begin
            nerrors++;
            $display("FAIL b2b_second got lat=%0d writes=%0d want %0d/4", lat, log_adr.size(), 2 * CPW + 1);
        end
        for (int i = 0; i < 4 && i < log_adr.size(); i++) begin
            ea = ((i < 2) ? 32'h300 : 32'h400) + 32'(4 * (i % 2));
            nchecks++;
            if (log_adr[i] !== ea || log_dat[i] !== w[i]) begin
                nerrors++;
                $display("FAIL b2b_wr%0d got %h:%h want %h:%h", i, log_adr[i], log_dat[i], ea, w[i]);
            end
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        logic [31:0] b, ea;
        int l, lat;
        stream_rand = 1'b1;
        for (int it = 0; it < 6; it++) begin
            clear_logs();
            w.delete();
            b = (it == 2) ? 32'hFFFF_FFF7 : $urandom;
            l = (it == 2) ? 4 : $urandom_range(1, 6);
            for (int i = 0; i < l; i++) begin
                w.push_back($urandom);
                stream_q.push_back(w[i]);
            end
            kick(b, l);
            wait_done(l * CPW * 6 + 20, lat);
            nchecks++;
            if (lat < 0 || err !== 1'b0 || log_adr.size() !== l || stream_q.size() !== 0) begin
                nerrors++;
                $display("FAIL rand%0d_count got lat=%0d err=%b writes=%0d left=%0d want done/0/%0d/0",
                         it, lat, err, log_adr.size(), stream_q.size(), l);
            end
            for (int i = 0; i < l && i < log_adr.size(); i++) begin
                ea = (b & 32'hFFFF_FFFC) + 32'(4 * i);
                nchecks++;
                if (log_adr[i] !== ea || log_dat[i] !== w[i]) begin
                    nerrors++;
                    $display("FAIL rand%0d_wr%0d got %h:%h want %h:%h", it, i, log_adr[i], log_dat[i], ea, w[i]);
                end
            end
            stream_q.delete();
            step();
        end
        stream_rand = 1'b0;
    endtask

`ifdef CHECKER_LOADER_VERIFY_EN
    task automatic test_verify();
        int lat;
        clear_logs();
        corrupt_en  = 1'b1;
        corrupt_adr = 32'h14;
        stream_q.push_back(32'hDEADBEEF);
        stream_q.push_back(32'h01234567);
        stream_q.push_back(32'hCAFEF00D);
        kick(32'h10, 3);
        wait_done(80, lat);
        nchecks++;
        if (lat !== 3 * CPW + 1 || log_adr.size() !== 3) begin
            nerrors++;
            $display("FAIL verify_run got lat=%0d writes=%0d want %0d/3", lat, log_adr.size(), 3 * CPW + 1);
        end
        nchecks++;
        if (err !== 1'b1 || fail_adr !== 32'h14) begin
            nerrors++;
            $display("FAIL verify_err got err=%b fail_adr=%h want 1/00000014", err, fail_adr);
        end
        corrupt_en = 1'b0;
        step();
    endtask
`endif

    task automatic test_invariants();
        nchecks++;
        if (inv_bad !== 0) begin
            nerrors++;
            $display("FAIL sel_cyc_invariant got %0d bad cycles want 0", inv_bad);
        end
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        start       = 1'b0;
        base_adr    = 32'h0;
        len         = 16'h0;
        abort       = 1'b0;
        s_dat       = 32'h0;
        s_valid     = 1'b0;
        wb_dat_i    = 32'h0;
        wb_ack_i    = 1'b0;
        rdata       = 32'h0;
        stream_en   = 1'b1;
        stream_rand = 1'b0;
        ack_en      = 1'b1;
        corrupt_en  = 1'b0;
        corrupt_adr = 32'h0;
        consumed    = 0;
        test_reset();
        test_basic();
        test_len0();
        test_timeout();
        test_abort();
        test_stall();
        test_back_to_back();
        test_random();
`ifdef CHECKER_LOADER_VERIFY_EN
        test_verify();
`endif
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish, %0d checks %0d errors so far", nchecks, nerrors);
        $fatal(1);
    end

endmodule
